// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver feeding a FIFO write port.
// Checks start, optional parity and stop bits; reports errors as single-cycle pulses.
module uart_rx #(
    parameter int WIDTH      = 8,
    parameter int DIV        = 27,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    input  logic             i_full,
    output logic             o_wr_en,
    output logic [WIDTH-1:0] o_w_data,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic             o_parity_err,
    output logic             o_overrun_err,
    output logic [2:0]       o_state
);

    localparam int DW = $clog2(DIV);
    localparam int BW = $clog2(WIDTH);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_rx_meta, r_rx_s, r_rx_prev;
    logic [DW-1:0]    r_div_cnt;
    logic [3:0]       r_s_cnt, w_s_cnt_nxt;
    logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic             r_par_bit, w_par_bit_nxt;
    logic             w_tick, w_fall, w_par_ok, w_mid, w_end;
    logic             w_wr_en, w_frame_err, w_parity_err, w_overrun_err;

    // Synchronizer and edge history preset high so reset release never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == DW'(DIV - 1)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    assign w_tick   = (r_div_cnt == DW'(DIV - 1));
    assign w_fall   = r_rx_prev & ~r_rx_s;
    assign w_mid    = w_tick && (r_s_cnt == 4'd7);
    assign w_end    = w_tick && (r_s_cnt == 4'd15);
    assign w_par_ok = (((^r_shift) ^ r_par_bit) == ODD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_s_cnt   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_cnt   <= w_s_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_par_bit <= w_par_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_s_cnt_nxt   = w_tick ? (r_s_cnt + 4'd1) : r_s_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_par_bit_nxt = r_par_bit;
        w_wr_en       = 1'b0;
        w_frame_err   = 1'b0;
        w_parity_err  = 1'b0;
        w_overrun_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_s_cnt_nxt = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_mid) begin
                    if (!r_rx_s) begin
                        w_s_cnt_nxt   = '0;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_end) begin
                    w_shift_nxt   = {r_rx_s, r_shift[WIDTH-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    if (r_bit_cnt == BW'(WIDTH - 1)) begin
                        w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_end) begin
                    w_par_bit_nxt = r_rx_s;
                    w_state_nxt   = S_STOP;
                end
            end
            S_STOP: begin
                // Framing beats parity beats overrun; exactly one outcome per frame.
                if (w_end) begin
                    w_state_nxt = S_IDLE;
                    if (!r_rx_s) begin
                        w_frame_err = 1'b1;
                    end else if ((PARITY_EN != 0) && !w_par_ok) begin
                        w_parity_err = 1'b1;
                    end else if (i_full) begin
                        w_overrun_err = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_wr_en       = w_wr_en;
    assign o_w_data      = r_shift;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_err   = w_frame_err;
    assign o_parity_err  = w_parity_err;
    assign o_overrun_err = w_overrun_err;
    assign o_state       = r_state;

endmodule
